// File: rtl/crc_serial_engine.sv
// Bit-serial CRC generator, MSB first, with runtime polynomial and start/busy/done handshake.
// Optional received-CRC compare (check/crc_in/crc_err) is built when CRC_SERIAL_CHECK_EN is defined.
module crc_serial_engine #(
    parameter int                DATA_W  = 14,
    parameter int                POLY_W  = 4,
    parameter logic [POLY_W-2:0] INIT    = '0,
    parameter logic [POLY_W-2:0] XOR_OUT = '0
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [DATA_W-1:0] Data,
    input  logic [POLY_W-1:0] Divisor,
`ifdef CRC_SERIAL_CHECK_EN
    input  logic              check,
    input  logic [POLY_W-2:0] crc_in,
    output logic              crc_err,
`endif
    output logic              busy,
    output logic              done,
    output logic [POLY_W-2:0] CRC,
    output logic              bad_poly
);

    // state | meaning
    // IDLE  | waiting for start; Data/Divisor captured on accept
    // LOAD  | remainder <- INIT, bit counter <- DATA_W
    // SHIFT | one message bit per clock, MSB first
    // DONE  | publish CRC/bad_poly, pulse done
    localparam int W  = POLY_W - 1;
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] msg_reg;
    logic [POLY_W-1:0] poly_reg;
    logic [W-1:0]      rem;
    logic [CW-1:0]     cnt;
    logic              fb;
    logic [W-1:0]      rem_nxt;
    logic [W-1:0]      rem_out;

`ifdef CRC_SERIAL_CHECK_EN
    logic              check_reg;
    logic [W-1:0]      crc_in_reg;
`endif

    // Shift form instead of a {rem[W-2:0],0} slice so a 1-bit CRC still elaborates.
    always_comb begin
        fb      = rem[W-1] ^ msg_reg[DATA_W-1];
        rem_nxt = (rem << 1) ^ (fb ? poly_reg[W-1:0] : '0);
        rem_out = rem ^ XOR_OUT;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            msg_reg  <= '0;
            poly_reg <= '0;
            rem      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            CRC      <= '0;
            bad_poly <= 1'b0;
`ifdef CRC_SERIAL_CHECK_EN
            check_reg  <= 1'b0;
            crc_in_reg <= '0;
            crc_err    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        msg_reg  <= Data;
                        poly_reg <= Divisor;
                        busy     <= 1'b1;
                        state    <= LOAD;
`ifdef CRC_SERIAL_CHECK_EN
                        check_reg  <= check;
                        crc_in_reg <= crc_in;
`endif
                    end
                end
                LOAD: begin
                    rem   <= INIT;
                    cnt   <= CW'(DATA_W);
                    state <= SHIFT;
                end
                SHIFT: begin
                    rem     <= rem_nxt;
                    msg_reg <= msg_reg << 1;
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    bad_poly <= ~poly_reg[POLY_W-1];
                    CRC      <= poly_reg[POLY_W-1] ? rem_out : '0;
`ifdef CRC_SERIAL_CHECK_EN
                    crc_err  <= check_reg &
                                ((rem_out != crc_in_reg) | ~poly_reg[POLY_W-1]);
`endif
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_serial_engine.sv
// Scoreboard bench for crc_serial_engine: directed vectors, parameter variants and a small sweep.
module tb_crc_serial_engine;

    typedef struct {
        logic [31:0] crc;
        logic        bad;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared stimulus for the three DATA_W=14 / POLY_W=4 instances
    logic        start = 1'b0;
    logic [13:0] Data = '0;
    logic [3:0]  Divisor = '0;
    logic        check = 1'b0;
    logic [2:0]  crc_in = '0;
    logic        chk_off = 1'b0;
    logic [2:0]  crc_in_off = '0;

    logic       busy0, done0, bad0, err0;
    logic [2:0] CRC0;
    logic       busy1, done1, bad1, err1;
    logic [2:0] CRC1;
    logic       busy2, done2, bad2, err2;
    logic [2:0] CRC2;

`ifdef CRC_SERIAL_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
    assign err0 = 1'b0;
    assign err1 = 1'b0;
    assign err2 = 1'b0;
`endif

    crc_serial_engine #(.DATA_W(14), .POLY_W(4), .INIT(3'b000), .XOR_OUT(3'b000)) dut0 (
        .clk(clk), .Reset(Reset), .start(start), .Data(Data), .Divisor(Divisor),
`ifdef CRC_SERIAL_CHECK_EN
        .check(check), .crc_in(crc_in), .crc_err(err0),
`endif
        .busy(busy0), .done(done0), .CRC(CRC0), .bad_poly(bad0));

    crc_serial_engine #(.DATA_W(14), .POLY_W(4), .INIT(3'b111), .XOR_OUT(3'b000)) dut1 (
        .clk(clk), .Reset(Reset), .start(start), .Data(Data), .Divisor(Divisor),
`ifdef CRC_SERIAL_CHECK_EN
        .check(chk_off), .crc_in(crc_in_off), .crc_err(err1),
`endif
        .busy(busy1), .done(done1), .CRC(CRC1), .bad_poly(bad1));

    crc_serial_engine #(.DATA_W(14), .POLY_W(4), .INIT(3'b000), .XOR_OUT(3'b111)) dut2 (
        .clk(clk), .Reset(Reset), .start(start), .Data(Data), .Divisor(Divisor),
`ifdef CRC_SERIAL_CHECK_EN
        .check(chk_off), .crc_in(crc_in_off), .crc_err(err2),
`endif
        .busy(busy2), .done(done2), .CRC(CRC2), .bad_poly(bad2));

    // Sweep instances
    logic        start_s = 1'b0;
    logic [31:0] ds = '0;
    logic [1:0]  dv1 = '0;
    logic [8:0]  dv2 = '0;
    logic [16:0] dv3 = '0;
    logic        bs1, dn1, bp1, es1;
    logic [0:0]  cs1;
    logic        bs2, dn2, bp2, es2;
    logic [7:0]  cs2;
    logic        bs3, dn3, bp3, es3;
    logic [15:0] cs3;
    logic [0:0]  ci1 = '0;
    logic [7:0]  ci2 = '0;
    logic [15:0] ci3 = '0;

`ifndef CRC_SERIAL_CHECK_EN
    assign es1 = 1'b0;
    assign es2 = 1'b0;
    assign es3 = 1'b0;
`endif

    crc_serial_engine #(.DATA_W(1), .POLY_W(2)) sw1 (
        .clk(clk), .Reset(Reset), .start(start_s), .Data(ds[0:0]), .Divisor(dv1),
`ifdef CRC_SERIAL_CHECK_EN
        .check(chk_off), .crc_in(ci1), .crc_err(es1),
`endif
        .busy(bs1), .done(dn1), .CRC(cs1), .bad_poly(bp1));

    crc_serial_engine #(.DATA_W(8), .POLY_W(9)) sw2 (
        .clk(clk), .Reset(Reset), .start(start_s), .Data(ds[7:0]), .Divisor(dv2),
`ifdef CRC_SERIAL_CHECK_EN
        .check(chk_off), .crc_in(ci2), .crc_err(es2),
`endif
        .busy(bs2), .done(dn2), .CRC(cs2), .bad_poly(bp2));

    crc_serial_engine #(.DATA_W(32), .POLY_W(17)) sw3 (
        .clk(clk), .Reset(Reset), .start(start_s), .Data(ds), .Divisor(dv3),
`ifdef CRC_SERIAL_CHECK_EN
        .check(chk_off), .crc_in(ci3), .crc_err(es3),
`endif
        .busy(bs3), .done(dn3), .CRC(cs3), .bad_poly(bp3));

    exp_t q0[$], q1[$], q2[$], qs1[$], qs2[$], qs3[$];

    // Bit-serial reference: remainder of data*x^w mod poly, seeded with init.
    function automatic logic [31:0] ref_crc(input logic [31:0] data, input int dw,
                                            input logic [31:0] poly, input int pw,
                                            input logic [31:0] init, input logic [31:0] xo);
        int          w;
        logic [31:0] mask;
        logic [31:0] rem;
        logic        fb;
        w    = pw - 1;
        mask = (32'h1 << w) - 32'h1;
        rem  = init & mask;
        if (poly[w] == 1'b0) return 32'h0;
        for (int i = dw - 1; i >= 0; i--) begin
            fb  = rem[w-1] ^ data[i];
            rem = ((rem << 1) & mask) ^ (fb ? (poly & mask) : 32'h0);
        end
        return (rem ^ xo) & mask;
    endfunction

    task automatic score(input string nm, input logic [31:0] crc, input logic bad,
                         input logic err, input exp_t e);
        checks++;
        if (crc !== e.crc || bad !== e.bad || cyc != e.cyc || (CHK_EN && err !== e.err)) begin
            errors++;
            $display("FAIL %s: got crc=%0h bad=%b err=%b cyc=%0d, expected crc=%0h bad=%b err=%b cyc=%0d",
                     nm, crc, bad, err, cyc, e.crc, e.bad, e.err, e.cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got done at cyc=%0d, expected no done", nm, cyc);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse
    logic prev_done0 = 1'b0;
    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) unexpected("dut0");
            else score("dut0", 32'(CRC0), bad0, err0, q0.pop_front());
            checks++;
            if (prev_done0) begin
                errors++;
                $display("FAIL dut0_done_width: got done high twice at cyc=%0d, expected single pulse", cyc);
            end
        end
        prev_done0 <= done0;
        if (done1) begin
            if (q1.size() == 0) unexpected("dut1");
            else score("dut1_init7", 32'(CRC1), bad1, err1, q1.pop_front());
        end
        if (done2) begin
            if (q2.size() == 0) unexpected("dut2");
            else score("dut2_xor7", 32'(CRC2), bad2, err2, q2.pop_front());
        end
        if (dn1) begin
            if (qs1.size() == 0) unexpected("sw1");
            else score("sw1", 32'(cs1), bp1, es1, qs1.pop_front());
        end
        if (dn2) begin
            if (qs2.size() == 0) unexpected("sw2");
            else score("sw2", 32'(cs2), bp2, es2, qs2.pop_front());
        end
        if (dn3) begin
            if (qs3.size() == 0) unexpected("sw3");
            else score("sw3", 32'(cs3), bp3, es3, qs3.pop_front());
        end
    end

    // Push expectations for an accept on the next edge (cyc+1); done follows DATA_W+2 edges later.
    task automatic expect3(input int acc, input logic [2:0] e0, input logic [2:0] e1,
                           input logic [2:0] e2, input logic bad, input logic eerr);
        q0.push_back('{crc: 32'(e0), bad: bad, err: eerr, cyc: acc + 16});
        q1.push_back('{crc: 32'(e1), bad: bad, err: 1'b0, cyc: acc + 16});
        q2.push_back('{crc: 32'(e2), bad: bad, err: 1'b0, cyc: acc + 16});
    endtask

    task automatic op(input logic [13:0] d, input logic [3:0] dv, input logic ck,
                      input logic [2:0] ci, input logic [2:0] e0, input logic [2:0] e1,
                      input logic [2:0] e2, input logic bad, input logic eerr);
        @(posedge clk); #1;
        Data = d; Divisor = dv; check = ck; crc_in = ci; start = 1'b1;
        expect3(cyc + 1, e0, e1, e2, bad, eerr);
        @(posedge clk); #1;
        start = 1'b0; Data = ~d; Divisor = 4'b1111; crc_in = ~ci;
        repeat (17) @(posedge clk);
    endtask

    localparam logic [13:0] A = 14'b11010011101100;

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion by cyc=%0d, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        #23;
        chk("reset_busy", 32'(busy0), 0);
        chk("reset_done", 32'(done0), 0);
        chk("reset_crc", 32'(CRC0), 0);
        chk("reset_bad", 32'(bad0), 0);
        @(posedge clk); #2;
        Reset = 1'b0;

        op(A,      4'b1011, 1'b0, 3'b000, 3'b100, 3'b011, 3'b011, 1'b0, 1'b0);
        op(14'd0,  4'b1011, 1'b0, 3'b000, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0);
        op(A,      4'b0011, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        op(A,      4'b1011, 1'b0, 3'b000, 3'b100, 3'b011, 3'b011, 1'b0, 1'b0);
`ifdef CRC_SERIAL_CHECK_EN
        op(A,      4'b1011, 1'b1, 3'b100, 3'b100, 3'b011, 3'b011, 1'b0, 1'b0);
        op(A,      4'b1011, 1'b1, 3'b101, 3'b100, 3'b011, 3'b011, 1'b0, 1'b1);
        op(A,      4'b0011, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1);
`endif

        // start held high across two operations; Data changed after the first accept
        @(posedge clk); #1;
        Data = A; Divisor = 4'b1011; check = 1'b0; start = 1'b1;
        c = cyc;
        expect3(c + 1,  3'b100, 3'b011, 3'b011, 1'b0, 1'b0);
        expect3(c + 18, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0);
        @(posedge clk); #1;
        Data = 14'd0;
        repeat (17) @(posedge clk);
        #1 start = 1'b0;
        repeat (18) @(posedge clk);

        // start raised mid-SHIFT with other Data/Divisor must be ignored
        @(posedge clk); #1;
        Data = A; Divisor = 4'b1011; start = 1'b1;
        expect3(cyc + 1, 3'b100, 3'b011, 3'b011, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1; Data = 14'h1555; Divisor = 4'b0011;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);

        // asynchronous reset 5 cycles into SHIFT: no done, outputs cleared at once
        @(posedge clk); #1;
        Data = 14'h2AAA; Divisor = 4'b1101; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        chk("pre_reset_busy", 32'(busy0), 1);
        Reset = 1'b1;
        #1;
        chk("async_reset_busy", 32'(busy0), 0);
        chk("async_reset_crc", 32'(CRC0), 0);
        chk("async_reset_crc_init7", 32'(CRC1), 0);
        chk("async_reset_done", 32'(done0), 0);
        @(posedge clk); #3;
        Reset = 1'b0;
        repeat (25) @(posedge clk);
        op(A, 4'b1011, 1'b0, 3'b000, 3'b100, 3'b011, 3'b011, 1'b0, 1'b0);

        // parameter sweep against the reference model
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            ds  = $urandom;
            dv1 = 2'b10 | 2'($urandom_range(0, 1));
            dv2 = 9'h100 | 9'($urandom_range(0, 255));
            dv3 = 17'h10000 | 17'($urandom_range(0, 65535));
            start_s = 1'b1;
            c = cyc;
            qs1.push_back('{crc: ref_crc(ds, 1,  32'(dv1), 2,  0, 0), bad: 1'b0, err: 1'b0, cyc: c + 4});
            qs2.push_back('{crc: ref_crc(ds, 8,  32'(dv2), 9,  0, 0), bad: 1'b0, err: 1'b0, cyc: c + 11});
            qs3.push_back('{crc: ref_crc(ds, 32, 32'(dv3), 17, 0, 0), bad: 1'b0, err: 1'b0, cyc: c + 35});
            @(posedge clk); #1;
            start_s = 1'b0;
            ds = ~ds;
            repeat (40) @(posedge clk);
        end

        for (int i = 0; i < 200 && (q0.size() + q1.size() + q2.size() +
                                    qs1.size() + qs2.size() + qs3.size()) > 0; i++)
            @(posedge clk);
        chk("drain_dut0", q0.size(), 0);
        chk("drain_dut1", q1.size(), 0);
        chk("drain_dut2", q2.size(), 0);
        chk("drain_sw1", qs1.size(), 0);
        chk("drain_sw2", qs2.size(), 0);
        chk("drain_sw3", qs3.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
